// File: rtl/led_pwm_dimmer.sv
// led_pwm_dimmer: 3-channel LED PWM dimmer with boundary-synchronised level updates.
// Define LED_PWM_FADE_EN to ramp levels by FADE_STEP per period instead of jumping to target.
module led_pwm_dimmer #(
  parameter int PRESCALE  = 47,
  parameter int FADE_STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       led_r_in,
  input  logic       led_g_in,
  input  logic       led_b_in,
  input  logic [7:0] bright_r,
  input  logic [7:0] bright_g,
  input  logic [7:0] bright_b,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic       fade_busy
);
  localparam int PW = PRESCALE > 0 ? $clog2(PRESCALE + 1) : 1;
  if (FADE_STEP < 1 || FADE_STEP > 255) begin : g_bad_step
    $error("FADE_STEP must be in 1..255");
  end
  logic [PW-1:0] pcnt;
  logic [7:0]    phase;
  logic [7:0]    tgt [3];
  logic [7:0]    lvl [3];
  logic [7:0]    nxt [3];
  logic [2:0]    pwm;
  logic          tick, bound, busy;
  assign tick  = pcnt == PW'(PRESCALE);
  assign bound = en && tick && phase == 8'hff;
  assign tgt[0] = led_r_in ? bright_r : 8'd0;
  assign tgt[1] = led_g_in ? bright_g : 8'd0;
  assign tgt[2] = led_b_in ? bright_b : 8'd0;
  assign {pwm_b, pwm_g, pwm_r} = pwm;
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
`ifdef LED_PWM_FADE_EN
      nxt[i] = tgt[i] > lvl[i]
             ? (tgt[i] - lvl[i] <= 8'(FADE_STEP) ? tgt[i] : lvl[i] + 8'(FADE_STEP))
             : (lvl[i] - tgt[i] <= 8'(FADE_STEP) ? tgt[i] : lvl[i] - 8'(FADE_STEP));
`else
      nxt[i] = tgt[i];
`endif
      busy = busy | (lvl[i] != tgt[i]);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt      <= '0;
      phase     <= '0;
      lvl       <= '{default: '0};
      pwm       <= '0;
      fade_busy <= 1'b0;
    end else begin
      pcnt      <= (!en || tick) ? '0 : pcnt + 1'b1;
      phase     <= !en ? 8'd0 : tick ? phase + 8'd1 : phase;
      fade_busy <= busy;
      for (int i = 0; i < 3; i++) begin
        lvl[i] <= !en ? tgt[i] : bound ? nxt[i] : lvl[i];
        pwm[i] <= en && (lvl[i] > phase);
      end
    end
  end
endmodule

// File: tb/tb_led_pwm_dimmer.sv
// tb_led_pwm_dimmer: table vectors, corner sequences and random stimulus against a period-level model.
module tb_led_pwm_dimmer;
  logic clk = 0, rst = 0, en = 0, lr = 0, lg = 0, lb = 0;
  logic [7:0] br = 0, bg = 0, bb = 0;
  logic pr, pg, pb, busy;
`ifdef LED_PWM_FADE_EN
  localparam bit FADE = 1;
`else
  localparam bit FADE = 0;
`endif
  localparam int STEP = 8;
  int n_chk = 0, n_fail = 0;
  int m_lvl[3];
  int m_ph = 0;

  typedef struct {
    bit en; bit [2:0] led; bit [7:0] r, g, b; int er, eg, eb;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  led_pwm_dimmer #(.PRESCALE(0), .FADE_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .en(en),
    .led_r_in(lr), .led_g_in(lg), .led_b_in(lb),
    .bright_r(br), .bright_g(bg), .bright_b(bb),
    .pwm_r(pr), .pwm_g(pg), .pwm_b(pb), .fade_busy(busy)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tgt(int c);
    case (c)
      0: return lr ? int'(br) : 0;
      1: return lg ? int'(bg) : 0;
      default: return lb ? int'(bb) : 0;
    endcase
  endfunction

  function automatic int fade(int l, int t);
    if (!FADE) return t;
    if (t > l) return (t - l <= STEP) ? t : l + STEP;
    return (l - t <= STEP) ? t : l - STEP;
  endfunction

  // one clk: predict from the state before the edge, then compare after it
  task automatic step();
    int e, eb;
    e = 0; eb = 0;
    for (int c = 0; c < 3; c++) begin
      if (en && m_lvl[c] > m_ph) e |= 1 << c;
      if (m_lvl[c] != tgt(c)) eb = 1;
    end
    for (int c = 0; c < 3; c++)
      m_lvl[c] = !en ? tgt(c) : (m_ph == 255 ? fade(m_lvl[c], tgt(c)) : m_lvl[c]);
    m_ph = en ? (m_ph + 1) % 256 : 0;
    @(posedge clk); #1;
    check("pwm", {pb, pg, pr}, e);
    check("fade_busy", busy, eb);
  endtask

  task automatic run(int n, output int hr, output int hg, output int hb, output int hz);
    hr = 0; hg = 0; hb = 0; hz = 0;
    repeat (n) begin
      step();
      hr += int'(pr); hg += int'(pg); hb += int'(pb); hz += int'(busy);
    end
  endtask

  task automatic do_reset();
    rst = 1; #1;
    check("rst_outputs", {pr, pg, pb, busy}, 0);
    m_lvl = '{0, 0, 0}; m_ph = 0;
    #2 rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hr, hg, hb, hz, k;
    tbl = '{
      '{1'b1, 3'b010, 8'd0,  8'd64,  8'd0,   0,  64,  0},
      '{1'b1, 3'b100, 8'd0,  8'd0,   8'd255, 0,  0,   255},
      '{1'b1, 3'b001, 8'd0,  8'd0,   8'd0,   0,  0,   0},
      '{1'b1, 3'b111, 8'd10, 8'd128, 8'd200, 10, 128, 200},
      '{1'b1, 3'b101, 8'd1,  8'd77,  8'd254, 1,  0,   254},
      '{1'b0, 3'b111, 8'd90, 8'd90,  8'd90,  0,  0,   0}
    };
    m_lvl = '{0, 0, 0};
    @(posedge clk); #1;
    do_reset();
    foreach (tbl[i]) begin
      {lb, lg, lr} = tbl[i].led; br = tbl[i].r; bg = tbl[i].g; bb = tbl[i].b;
      en = 0; step();
      en = tbl[i].en;
      run(256, hr, hg, hb, hz);
      check("tbl_duty_r", hr, tbl[i].er);
      check("tbl_duty_g", hg, tbl[i].eg);
      check("tbl_duty_b", hb, tbl[i].eb);
    end
    // reset mid-period, then level 0 must stay dark
    en = 1; lr = 0; lg = 1; lb = 0; bg = 64;
    run(300, hr, hg, hb, hz);
    do_reset();
    lr = 1; br = 0; lg = 0;
    run(1024, hr, hg, hb, hz);
    check("zero_level_r", hr, 0);
    check("zero_level_gb", hg + hb, 0);
    // green 64 from reset
    do_reset();
    lr = 0; lg = 1; bg = 64;
    run(256, hr, hg, hb, hz);
    for (k = 1; k <= 2; k++) begin
      run(256, hr, hg, hb, hz);
      check("g64_duty", hg, FADE ? (8 * k < 64 ? 8 * k : 64) : 64);
      check("g64_rb_dark", hr + hb, 0);
    end
    // red ramp 0 -> 100
    do_reset();
    lg = 0; lr = 1; br = 100;
    for (k = 0; k <= 13; k++) begin
      run(256, hr, hg, hb, hz);
      check("ramp_level", hr, k == 0 ? 0 : FADE ? (8 * k < 100 ? 8 * k : 100) : 100);
      if (k == 12) check("ramp_busy_k12", busy, FADE);
    end
    check("ramp_busy_done", busy, 0);
    // target change mid-period
    br = 32; en = 0; step(); en = 1;
    run(100, hr, hg, hb, hz);
    k = hr;
    br = 200;
    run(156, hr, hg, hb, hz);
    check("midperiod_duty", k + hr, 32);
    step();
    check("next_period_phase0", pr, 1);
    run(255, hr, hg, hb, hz);
    check("next_period_duty", hr + 1, FADE ? 40 : 200);
    // en dropped mid-fade
    br = 0; en = 0; step(); en = 1; br = 200;
    run(356, hr, hg, hb, hz);
    en = 0; step();
    check("en_low_pwm", {pb, pg, pr}, 0);
    step();
    check("en_low_busy", busy, 0);
    en = 1;
    run(256, hr, hg, hb, hz);
    check("en_restart_duty", hr, 200);
    check("en_restart_busy", hz, 0);
    // random stimulus
    repeat (20) begin
      en = $urandom_range(0, 4) != 0;
      {lb, lg, lr} = 3'($urandom);
      br = 8'($urandom); bg = 8'($urandom); bb = 8'($urandom);
      if ($urandom_range(0, 9) == 0) do_reset();
      run($urandom_range(1, 600), hr, hg, hb, hz);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/led_pwm_dimmer.md
LED_PWM_DIMMER -- requirements
Module: led_pwm_dimmer

Interface
REQ-001 Parameter PRESCALE, default 47, sets the PWM tick divider; one tick every PRESCALE+1 clk cycles (≈977 Hz PWM period at 12 MHz).
REQ-002 Parameter FADE_STEP, default 8, gives the 8-bit level change per PWM period while fading (1..255).
REQ-003 clk  in  1  system clock, 12 MHz nominal.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 en  in  1  dimmer enable; low forces outputs off.
REQ-006 led_r_in, led_g_in, led_b_in  in  1 each  on/off colour bits from the upstream LED sequencer.
REQ-007 bright_r, bright_g, bright_b  in  8 each  per-channel brightness when the channel is on.
REQ-008 pwm_r, pwm_g, pwm_b  out  1 each  registered PWM drive to the LED pins.
REQ-009 fade_busy  out  1  high while any channel's active level differs from its target.

Function
REQ-010 Prescaler counts 0..PRESCALE and wraps; tick is asserted for the single cycle where the count equals PRESCALE.
REQ-011 8-bit phase counter increments on each tick and wraps 255->0; PWM period = 256*(PRESCALE+1) clk cycles.
REQ-012 Per-channel target = led_x_in ? bright_x : 8'd0, evaluated combinationally every cycle.
REQ-013 Period boundary = a tick with phase==255; the active level (8-bit register per channel) changes only at a period boundary, so no duty change occurs mid-period.
REQ-014 pwm_x is registered: pwm_x <= en && (active_level_x > phase); output lags the compare by 1 clk.
REQ-015 Duty = active_level/256: level 0 gives a constant low, and level 255 is high for 255 of 256 phases.
REQ-016 fade_busy is registered: high when any channel's active_level != target, evaluated each cycle.
REQ-017 When en is low, the prescaler and phase are held at 0, all pwm_x are 0 on the next clk, and each active_level loads its target every cycle (no fade).
REQ-018 On the en rising edge, counting restarts from prescaler=0 and phase=0, and the first full period uses the levels loaded while disabled.
REQ-019 A target change mid-period is not visible until the next period boundary, and the target is re-evaluated at each boundary (the last value wins).
REQ-020 All three channels update simultaneously at the same boundary and share one prescaler and phase counter.

Reset
REQ-021 During rst: prescaler=0, phase=0, all active_level=0, pwm_r/g/b=0, fade_busy=0.
REQ-022 After rst deasserts, the first tick occurs PRESCALE+1 clk cycles later if en is high, and fade_busy reflects the targets from the first clk edge.
REQ-023 rst asserted mid-fade or mid-period aborts immediately to the REQ-021 values, and no partial level is retained.

Configuration
REQ-024 Macro LED_PWM_FADE_EN defined: at each boundary, active_level moves toward target by FADE_STEP; if |target-level| <= FADE_STEP it loads target exactly (no overshoot, no 8-bit wrap).
REQ-025 Macro LED_PWM_FADE_EN undefined: at each boundary, active_level loads target directly; fade_busy is high only between a target change and the next boundary; the FADE_STEP parameter is accepted but unused.

Verification
REQ-026 The bench shall run with PRESCALE=0 (period 256 clk) and shall cover the following scenarios.
REQ-027 Scenario: rst pulse mid-period -> all outputs 0 within the same cycle; after release with en=1, led_r_in=1, bright_r=0 -> pwm_r stays 0 for 1024 cycles.
REQ-028 Scenario: fade off, led_g_in=1, bright_g=64, en=1 -> from the 2nd period, pwm_g is high exactly 64 of every 256 cycles; pwm_r and pwm_b stay 0.
REQ-029 Scenario: bright_b=255, led_b_in=1 -> pwm_b is high 255 and low 1 per period, with the low cycle at phase 255.
REQ-030 Scenario: fade on, FADE_STEP=8, red target 0->100 -> successive period levels are 8,16,...,96,100; fade_busy falls the cycle after level reaches 100 (13 boundaries).
REQ-031 Scenario: bright_r changed 32->200 at phase 100 -> the duty of the current period stays 32/256, and the new duty (fade off) starts at phase 0 of the next period.
REQ-032 Scenario: en dropped mid-fade -> pwm outputs 0 one clk later and active_level equals target; en raised -> full target duty in the first period and fade_busy stays 0.
